// File: rtl/grant_owner_ctrl_if.sv
// grant_owner_ctrl_if: client, arbiter and shared-resource signals of grant_owner_ctrl
interface grant_owner_ctrl_if #(
    parameter int N  = 8,
    parameter int DW = 32
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    logic [N-1:0]    cli_req;
    logic [N*DW-1:0] cli_data;
    logic [N-1:0]    cli_last;
    logic [N-1:0]    arb_req;
    logic [N-1:0]    arb_gnt;
    logic [N-1:0]    cli_ack;
    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic            res_last;
    logic            res_ready;
    logic [OW-1:0]   res_owner;
    logic            busy;
    logic            err_multi_gnt;
    logic            timeout;
    modport master (
        input  cli_req, cli_data, cli_last, arb_gnt, res_ready,
        output arb_req, cli_ack, res_valid, res_data, res_last, res_owner, busy, err_multi_gnt, timeout
    );
    modport slave (
        output cli_req, cli_data, cli_last, arb_gnt, res_ready,
        input  arb_req, cli_ack, res_valid, res_data, res_last, res_owner, busy, err_multi_gnt, timeout
    );
endinterface

// File: rtl/grant_owner_ctrl.sv
// grant_owner_ctrl: latches the arbiter winner and holds the shared resource for its burst; `define HOLD_TIMEOUT_EN adds a forced release after MAX_HOLD LOCKED cycles
module grant_owner_ctrl #(
    parameter int N        = 8,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 16
) (
    input logic               clk,
    input logic               rst_n,
    grant_owner_ctrl_if.master bus
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] IDLE = 2'd0, LOCKED = 2'd1, RELEASE = 2'd2;
    if (N < 2 || (N & (N - 1)) != 0 || MAX_HOLD < 2) begin : g_bad_param
        $error("grant_owner_ctrl: N must be a power of 2 >= 2 and MAX_HOLD >= 2");
    end
    logic [1:0]    state;
    logic [OW-1:0] owner, gnt_idx;
    logic          idle, locked, gnt_multi, gnt_one, take, beat, done, tmo_hit, multi_q, tmo_q;
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) gnt_idx = bus.arb_gnt[i] ? OW'(i) : gnt_idx;
    end
    assign idle      = state == IDLE;
    assign locked    = state == LOCKED;
    assign gnt_multi = |(bus.arb_gnt & (bus.arb_gnt - N'(1)));
    assign gnt_one   = |bus.arb_gnt & ~gnt_multi;
    // a grant is only honoured if the winner still requests (stale grants are dropped)
    assign take      = idle & gnt_one & bus.cli_req[gnt_idx];
    assign beat      = bus.res_valid & bus.res_ready;
    assign done      = (beat & bus.res_last) | ~bus.cli_req[owner];
    assign bus.arb_req       = (idle && rst_n) ? bus.cli_req : '0;
    assign bus.busy          = !idle;
    assign bus.res_owner     = owner;
    assign bus.res_valid     = locked & bus.cli_req[owner];
    assign bus.res_data      = locked ? bus.cli_data[int'(owner)*DW +: DW] : '0;
    assign bus.res_last      = locked & bus.cli_last[owner];
    assign bus.cli_ack       = beat ? (N'(1) << owner) : '0;
    assign bus.err_multi_gnt = multi_q;
    assign bus.timeout       = tmo_q;
`ifdef HOLD_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD) + 1;
    logic [CW-1:0] hold_cnt;
    always_ff @(posedge clk) begin
        hold_cnt <= (!rst_n || !locked) ? '0 : hold_cnt + CW'(1);
    end
    // an accepted last beat or an abort in the final cycle is a normal release
    assign tmo_hit = locked & ~done & (hold_cnt == CW'(MAX_HOLD - 1));
`else
    assign tmo_hit = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            multi_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state   <= idle ? (take ? LOCKED : IDLE) : locked ? ((done | tmo_hit) ? RELEASE : LOCKED) : IDLE;
            owner   <= take ? gnt_idx : owner;
            multi_q <= idle & gnt_multi;
            tmo_q   <= tmo_hit;
        end
    end
endmodule

// File: tb/tb_grant_owner_ctrl.sv
// tb_grant_owner_ctrl: directed plan scenarios plus random traffic against an ownership-level reference model
module tb_grant_owner_ctrl;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int MH = 16;
    logic clk = 1'b0;
    logic rst_n;
    int n_chk = 0, n_fail = 0;
    int own = -1, last_own = 0, age = 0, acks = 0, tmos = 0;
    bit in_rel = 0, exp_err = 0, exp_tmo = 0;
    logic [N-1:0] act;
    grant_owner_ctrl_if #(.N(N), .DW(DW)) b ();
    grant_owner_ctrl #(.N(N), .DW(DW), .MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(b.master));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drv(input logic [N-1:0] req, input logic [N-1:0] gnt, input logic [N-1:0] last,
                       input logic rdy, input int c, input logic [DW-1:0] d);
        for (int i = 0; i < N; i++) b.cli_data[i*DW +: DW] = $urandom;
        b.cli_data[c*DW +: DW] = d;
        b.cli_req = req;
        b.arb_gnt = gnt;
        b.cli_last = last;
        b.res_ready = rdy;
    endtask

    // check outputs mid-cycle, then advance the ownership model across the edge
    task automatic step();
        bit free, vld, fin, to, n_rel, n_err, n_tmo;
        int n_own, n_last, n_age, k;
        #2;
        free = own < 0 && !in_rel;
        vld  = own >= 0 ? b.cli_req[own] : 1'b0;
        chk("arb_req", b.arb_req, (free && rst_n) ? b.cli_req : '0);
        chk("busy", b.busy, !free);
        chk("res_owner", b.res_owner, last_own);
        chk("res_valid", b.res_valid, vld);
        chk("cli_ack", b.cli_ack, (vld && b.res_ready) ? (64'd1 << own) : 64'd0);
        chk("err_multi_gnt", b.err_multi_gnt, exp_err);
        chk("timeout", b.timeout, exp_tmo);
        if (own >= 0 || !rst_n) begin
            chk("res_data", b.res_data, own >= 0 ? b.cli_data[own*DW +: DW] : '0);
            chk("res_last", b.res_last, own >= 0 ? b.cli_last[own] : 1'b0);
        end
        acks += (b.cli_ack != 0);
        tmos += b.timeout;
        n_own = own; n_rel = in_rel; n_age = age; n_last = last_own; n_err = 0; n_tmo = 0;
        if (!rst_n) begin
            n_own = -1; n_rel = 0; n_age = 0; n_last = 0;
        end else if (free) begin
            n_err = $countones(b.arb_gnt) > 1;
            if ($countones(b.arb_gnt) == 1) begin
                k = $clog2(b.arb_gnt);
                if (b.cli_req[k]) begin n_own = k; n_last = k; n_age = 0; end
            end
        end else if (in_rel) begin
            n_rel = 0;
        end else begin
            fin = (vld && b.res_ready && b.cli_last[own]) || !b.cli_req[own];
`ifdef HOLD_TIMEOUT_EN
            to = !fin && (age + 1 == MH);
`else
            to = 0;
`endif
            if (fin || to) begin n_own = -1; n_rel = 1; n_tmo = to; end
            else n_age = age + 1;
        end
        @(posedge clk);
        own = n_own; in_rel = n_rel; age = n_age; last_own = n_last; exp_err = n_err; exp_tmo = n_tmo;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        drv(8'hFF, 8'h04, 8'h00, 1'b0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        repeat (3) step();
        rst_n = 1;
        step();
        // single burst, owner 2
        acks = 0;
        drv(8'h04, 8'h00, 8'h00, 1'b1, 2, 32'hD000_0000); step();
        drv(8'h04, 8'h00, 8'h00, 1'b1, 2, 32'hD000_0001); step();
        drv(8'h04, 8'h00, 8'h04, 1'b1, 2, 32'hD000_0002); step();
        drv(8'h00, 8'h00, 8'h00, 1'b1, 0, 0); step(); step();
        chk("burst_acks", acks, 3);
        // backpressure mid-burst
        acks = 0;
        drv(8'h04, 8'h04, 8'h00, 1'b1, 2, 32'hB0); step();
        drv(8'h04, 8'h00, 8'h00, 1'b1, 2, 32'hB0); step();
        drv(8'h04, 8'h00, 8'h00, 1'b0, 2, 32'hB1); step(); step();
        drv(8'h04, 8'h00, 8'h00, 1'b1, 2, 32'hB1); step();
        drv(8'h04, 8'h00, 8'h04, 1'b1, 2, 32'hB2); step();
        drv(8'h00, 8'h00, 8'h00, 1'b1, 0, 0); step(); step();
        chk("bp_acks", acks, 3);
        // abort by owner 5 after one beat
        acks = 0;
        drv(8'h20, 8'h20, 8'h00, 1'b1, 5, 32'hA0); step();
        drv(8'h20, 8'h00, 8'h00, 1'b1, 5, 32'hA1); step();
        drv(8'h00, 8'h00, 8'h00, 1'b1, 5, 32'hA2); step(); step(); step();
        chk("abort_acks", acks, 1);
        // stale grant, then multi-hot grant
        drv(8'h01, 8'h10, 8'h00, 1'b1, 0, 0); step(); step();
        drv(8'h03, 8'h03, 8'h00, 1'b1, 0, 0); step();
        drv(8'h03, 8'h00, 8'h00, 1'b1, 0, 0); step(); step();
        // owner 7 stalls with res_ready low
        tmos = 0;
        drv(8'h80, 8'h80, 8'h00, 1'b0, 7, 32'h77); step();
        drv(8'h80, 8'h00, 8'h00, 1'b0, 7, 32'h77);
        repeat (20) step();
`ifdef HOLD_TIMEOUT_EN
        chk("timeout_pulses", tmos, 1);
`else
        chk("timeout_pulses", tmos, 0);
`endif
        drv(8'h00, 8'h00, 8'h00, 1'b0, 0, 0); step(); step(); step();
        // random traffic with slowly changing requests
        act = '0;
        for (int t = 0; t < 3000; t++) begin
            logic [N-1:0] g;
            int r;
            for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) act[i] = ~act[i];
            r = $urandom_range(99);
            g = r < 55 ? N'(1) << $urandom_range(N - 1) : r < 85 ? '0 : N'($urandom);
            rst_n = $urandom_range(199) != 0;
            drv(act, g, N'($urandom_range(3) == 0 ? $urandom : 0), $urandom_range(3) != 0, 0, $urandom);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
